// File: rtl/pin_sched_if.sv
// Requester-side bundle for pin_sched: per-requester request, compressed data, pin mask and grant ack.
// IO_PINS falls back to 16 when the codebase-wide macro has not been defined earlier in the build.
`ifndef IO_PINS
`define IO_PINS 16
`endif

interface pin_sched_if #(
  parameter int NREQ = 4,
  parameter int PINS = `IO_PINS
);
  logic [NREQ-1:0]      req;
  logic [NREQ*PINS-1:0] data;
  logic [NREQ*PINS-1:0] mask;
  logic [NREQ-1:0]      ack;

  modport master (output req, data, mask, input ack);
  modport slave  (input req, data, mask, output ack);
endinterface

// File: rtl/pin_sched.sv
// pin_sched: round-robin share of one pin_decompress among NREQ requesters, merged into a held pin register.
// PIN_SCHED_PIPE_EN adds a grant register stage (pins_out/upd_* latency 2 instead of 1); ack stays combinational.
`ifndef IO_PINS
`define IO_PINS 16
`endif

module pin_decompress #(
  parameter int PINS = `IO_PINS
) (
  input  logic [PINS-1:0] i_data,
  input  logic [PINS-1:0] i_mask,
  output logic [PINS-1:0] o_exp
);
  localparam int IW = $clog2(PINS);

  logic [IW-1:0] w_idx;

  // Compressed bit k lands on the k-th set mask bit counting from pin 0.
  always_comb begin
    o_exp = '0;
    w_idx = '0;
    for (int j = 0; j < PINS; j++) begin
      if (i_mask[j]) begin
        o_exp[j] = i_data[w_idx];
        w_idx    = w_idx + IW'(1);
      end
    end
  end
endmodule

module pin_sched #(
  parameter  int NREQ = 4,
  localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  pin_sched_if.slave          io_bus,
  output logic [`IO_PINS-1:0] o_pins_out,
  output logic                o_upd_valid,
  output logic [IDW-1:0]      o_upd_id
);
  localparam int PINS = `IO_PINS;
  localparam int CW   = IDW + 1;

  logic [IDW-1:0]  r_ptr;
  logic [CW-1:0]   w_cand;
  logic            w_gnt_vld;
  logic [IDW-1:0]  w_gnt_id;
  logic [PINS-1:0] w_win_dat;
  logic [PINS-1:0] w_win_msk;

  logic            w_upd_vld;
  logic [PINS-1:0] w_upd_dat;
  logic [PINS-1:0] w_upd_msk;
  logic [IDW-1:0]  w_upd_id;
  logic [PINS-1:0] w_exp;

  logic [PINS-1:0] r_pins;
  logic            r_upd_vld;
  logic [IDW-1:0]  r_upd_id;

  // Walk from the farthest candidate back to ptr so the nearest requester is the last one assigned.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_id  = '0;
    w_cand    = '0;
    for (int off = NREQ - 1; off >= 0; off--) begin
      w_cand = {1'b0, r_ptr} + CW'(off);
      if (w_cand >= CW'(NREQ)) begin
        w_cand = w_cand - CW'(NREQ);
      end
      if (io_bus.req[w_cand[IDW-1:0]]) begin
        w_gnt_vld = 1'b1;
        w_gnt_id  = w_cand[IDW-1:0];
      end
    end
  end

  always_comb begin
    io_bus.ack = '0;
    if (w_gnt_vld && rst_n) begin
      io_bus.ack[w_gnt_id] = 1'b1;
    end
  end

  assign w_win_dat = io_bus.data[int'(w_gnt_id)*PINS +: PINS];
  assign w_win_msk = io_bus.mask[int'(w_gnt_id)*PINS +: PINS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (w_gnt_vld) begin
      r_ptr <= (w_gnt_id == IDW'(NREQ - 1)) ? '0 : w_gnt_id + IDW'(1);
    end
  end

`ifdef PIN_SCHED_PIPE_EN
  logic            r_pipe_vld;
  logic [PINS-1:0] r_pipe_dat;
  logic [PINS-1:0] r_pipe_msk;
  logic [IDW-1:0]  r_pipe_id;

  // Grant stage: the winner is frozen here so decompress starts from a register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pipe_vld <= 1'b0;
      r_pipe_dat <= '0;
      r_pipe_msk <= '0;
      r_pipe_id  <= '0;
    end else begin
      r_pipe_vld <= w_gnt_vld;
      if (w_gnt_vld) begin
        r_pipe_dat <= w_win_dat;
        r_pipe_msk <= w_win_msk;
        r_pipe_id  <= w_gnt_id;
      end
    end
  end

  assign w_upd_vld = r_pipe_vld;
  assign w_upd_dat = r_pipe_dat;
  assign w_upd_msk = r_pipe_msk;
  assign w_upd_id  = r_pipe_id;
`else
  assign w_upd_vld = w_gnt_vld;
  assign w_upd_dat = w_win_dat;
  assign w_upd_msk = w_win_msk;
  assign w_upd_id  = w_gnt_id;
`endif

  pin_decompress #(.PINS(PINS)) u_decomp (
    .i_data (w_upd_dat),
    .i_mask (w_upd_msk),
    .o_exp  (w_exp)
  );

  // Unmasked pins hold; an empty mask still reports an update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pins    <= '0;
      r_upd_vld <= 1'b0;
      r_upd_id  <= '0;
    end else begin
      r_upd_vld <= w_upd_vld;
      if (w_upd_vld) begin
        r_pins   <= (r_pins & ~w_upd_msk) | w_exp;
        r_upd_id <= w_upd_id;
      end
    end
  end

  assign o_pins_out  = r_pins;
  assign o_upd_valid = r_upd_vld;
  assign o_upd_id    = r_upd_id;
endmodule

// File: tb/tb_pin_sched.sv
// Bench for pin_sched: reference model checked every negedge plus directed literal expectations.
`timescale 1ns/1ps
`ifndef IO_PINS
`define IO_PINS 16
`endif

module tb_pin_sched;
  localparam int NREQ = 4;
  localparam int P    = `IO_PINS;
`ifdef PIN_SCHED_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic            clk   = 1'b0;
  logic            rst_n = 1'b0;
  logic [NREQ-1:0] req;
  logic [P-1:0]    d [NREQ];
  logic [P-1:0]    m [NREQ];
  logic [P-1:0]    pins;
  logic            upd_v;
  logic [1:0]      upd_id;

  int checks = 0;
  int errors = 0;

  pin_sched_if #(.NREQ(NREQ), .PINS(P)) bus ();

  pin_sched #(.NREQ(NREQ)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .io_bus      (bus),
    .o_pins_out  (pins),
    .o_upd_valid (upd_v),
    .o_upd_id    (upd_id)
  );

  always #5 clk = ~clk;

  assign bus.req = req;
  always_comb begin
    bus.data = '0;
    bus.mask = '0;
    for (int i = 0; i < NREQ; i++) begin
      bus.data[i*P +: P] = d[i];
      bus.mask[i*P +: P] = m[i];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    bit           v;
    logic [P-1:0] d;
    logic [P-1:0] m;
    int           id;
  } upd_t;

  function automatic logic [P-1:0] expand(input logic [P-1:0] dd, input logic [P-1:0] mm);
    int           pos[$];
    logic [P-1:0] r;
    r = '0;
    for (int j = 0; j < P; j++) if (mm[j]) pos.push_back(j);
    foreach (pos[k]) r[pos[k]] = dd[k];
    return r;
  endfunction

  function automatic int pick(input logic [NREQ-1:0] rq, input int p);
    for (int off = 0; off < NREQ; off++) begin
      if (rq[(p + off) % NREQ]) return (p + off) % NREQ;
    end
    return -1;
  endfunction

  initial begin
    upd_t            dq [LAT];
    upd_t            cur;
    upd_t            out;
    int              m_ptr;
    int              m_id;
    int              w;
    bit              m_vld;
    logic [P-1:0]    m_pins;
    logic [NREQ-1:0] eack;
    m_ptr = 0; m_id = 0; m_vld = 0; m_pins = '0;
    foreach (dq[i]) dq[i].v = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_ptr = 0; m_id = 0; m_vld = 0; m_pins = '0;
        foreach (dq[i]) dq[i].v = 0;
      end
      chk("model_pins", pins, m_pins);
      chk("model_upd_valid", upd_v, m_vld);
      if (m_vld) chk("model_upd_id", upd_id, m_id);
      w = rst_n ? pick(req, m_ptr) : -1;
      eack = '0;
      if (w >= 0) eack[w] = 1'b1;
      chk("model_ack", bus.ack, eack);
      if (rst_n) begin
        cur.v = (w >= 0);
        cur.d = '0; cur.m = '0; cur.id = 0;
        if (w >= 0) begin
          cur.d = d[w]; cur.m = m[w]; cur.id = w;
          m_ptr = (w + 1) % NREQ;
        end
        for (int i = LAT - 1; i > 0; i--) dq[i] = dq[i-1];
        dq[0] = cur;
        out   = dq[LAT-1];
        m_vld = out.v;
        if (out.v) begin
          m_pins = (m_pins & ~out.m) | expand(out.d, out.m);
          m_id   = out.id;
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  initial begin
    logic [NREQ-1:0] exp_rr [6];
    logic            b [4];
    exp_rr = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    req = '0;
    foreach (d[i]) begin d[i] = '0; m[i] = '0; end

    repeat (3) tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("idle_ack", bus.ack, 4'b0000);
      chk("idle_pins", pins, 16'h0000);
      chk("idle_upd_valid", upd_v, 1'b0);
      tick();
    end

    // single write
    d[0] = 16'h000B; m[0] = 16'h5145; req = 4'b0001;
    #1 chk("single_ack", bus.ack, 4'b0001);
    tick(); req = '0;
    repeat (LAT - 1) tick();
    #1;
    chk("single_pins", pins, 16'h0105);
    chk("single_upd_valid", upd_v, 1'b1);
    chk("single_upd_id", upd_id, 2'd0);
    tick();

    // masked merge onto an all-ones register
    d[0] = 16'hFFFF; m[0] = 16'hFFFF; req = 4'b0001;
    tick();
    d[2] = 16'h0000; m[2] = 16'h00F0; req = 4'b0100;
    #1 chk("merge_ack", bus.ack, 4'b0100);
    tick(); req = '0;
    repeat (LAT - 1) tick();
    #1;
    chk("merge_pins", pins, 16'hFF0F);
    chk("merge_upd_id", upd_id, 2'd2);
    tick();

    // round-robin with every request held from reset
    rst_n = 1'b0;
    d[1] = 16'h00FF; m[1] = 16'h0F00;
    d[3] = 16'h0003; m[3] = 16'hC000;
    req = 4'b1111;
    #1 chk("rr_reset_ack", bus.ack, 4'b0000);
    tick(); tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1 chk("rr_ack_order", bus.ack, exp_rr[i]);
      tick();
    end
    req = '0;
    tick();

    // reset mid-operation
    req = 4'b0010;
    #1 chk("rst_ack1", bus.ack, 4'b0010);
    tick();
    rst_n = 1'b0; req = '0;
    #1;
    chk("rst_pins", pins, 16'h0000);
    chk("rst_upd_valid", upd_v, 1'b0);
    tick(); tick();
    rst_n = 1'b1;
    repeat (2) begin
      #1 chk("rst_post_upd_valid", upd_v, 1'b0);
      chk("rst_post_pins", pins, 16'h0000);
      tick();
    end
    req = 4'b1111;
    #1 chk("rst_next_grant", bus.ack, 4'b0001);
    tick(); req = '0;
    repeat (3) tick();

    // back-to-back grants with an overlapping mask bit
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    d[0] = 16'h0001; m[0] = 16'h0001;
    d[1] = 16'h0000; m[1] = 16'h0001;
    req = 4'b0011;
    #1 chk("b2b_ack0", bus.ack, 4'b0001);
    b[0] = pins[0];
    for (int k = 1; k < 4; k++) begin
      tick();
      req = (k == 1) ? 4'b0010 : 4'b0000;
      #1 b[k] = pins[0];
    end
    chk("b2b_bit0_first", b[LAT], 1'b1);
    chk("b2b_bit0_second", b[LAT+1], 1'b0);

    // empty mask is still acked and reported
    d[3] = 16'hFFFF; m[3] = 16'h0000; req = 4'b1000;
    tick(); req = '0;
    repeat (LAT - 1) tick();
    #1;
    chk("zero_mask_upd_valid", upd_v, 1'b1);
    chk("zero_mask_upd_id", upd_id, 2'd3);
    chk("zero_mask_pins", pins, 16'h0000);
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
